key_conditioner: RTL and testbench

- Input-side counterpart to the display path: takes raw active-low push-button inputs and delivers clean, synchronous key events to the reaction-timer FSM.
- Per key: 2-flop synchronizer, debounce counter, press/release one-cycle pulses, and a one-shot long-press (hold) pulse.
- Runs on the 1 kHz system tick clock. Sits between KEY[1:0] and the state machine's start/stop inputs.

---
 rtl/key_conditioner.sv | 124 ++++++++++++
 tb/tb_key_conditioner.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-flop sync, debounce, press/release pulses
// and a one-shot long-press pulse per key.
module key_conditioner #(
  parameter int N_KEYS         = 2,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int HOLD_TICKS     = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] hold_pulse,
  output logic              any_pressed
);

  localparam int DW = $clog2(DEBOUNCE_TICKS) + 1;
  localparam int HW = $clog2(HOLD_TICKS) + 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESSED_COUNTING,
    HELD
  } hold_state_t;

  logic [N_KEYS-1:0] ff1, ff2;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1 <= '1;
      ff2 <= '1;
    end else begin
      ff1 <= key_n;
      ff2 <= ff1;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic [DW-1:0] db_cnt, db_cnt_nx;
    logic [HW-1:0] h_cnt, h_cnt_nx;
    hold_state_t   st, st_nx;
    logic          p_q, pp_q, rp_q, hp_q;
    logic          sync_p, flip, rise, fall, hold_nx;

    always_comb begin
      sync_p    = ~ff2[k];
      flip      = 1'b0;
      db_cnt_nx = '0;
      if (sync_p != p_q) begin
        if (db_cnt == DMAX) flip = 1'b1;
        else db_cnt_nx = db_cnt + 1'b1;
      end
      rise = flip & ~p_q;
      fall = flip & p_q;
    end

    // A release on the hold edge takes priority over the hold pulse.
    always_comb begin
      st_nx    = st;
      h_cnt_nx = h_cnt;
      hold_nx  = 1'b0;
      case (st)
        RELEASED: begin
          if (rise) begin
            st_nx    = PRESSED_COUNTING;
            h_cnt_nx = '0;
          end
        end
        PRESSED_COUNTING: begin
          if (fall) begin
            st_nx    = RELEASED;
            h_cnt_nx = '0;
          end else if (h_cnt == HMAX) begin
            st_nx   = HELD;
            hold_nx = 1'b1;
          end else begin
            h_cnt_nx = h_cnt + 1'b1;
          end
        end
        HELD: begin
          if (fall) begin
            st_nx    = RELEASED;
            h_cnt_nx = '0;
          end
        end
        default: begin
          st_nx    = RELEASED;
          h_cnt_nx = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt <= '0;
        h_cnt  <= '0;
        st     <= RELEASED;
        p_q    <= 1'b0;
        pp_q   <= 1'b0;
        rp_q   <= 1'b0;
        hp_q   <= 1'b0;
      end else begin
        db_cnt <= db_cnt_nx;
        h_cnt  <= h_cnt_nx;
        st     <= st_nx;
        p_q    <= p_q ^ flip;
        pp_q   <= rise;
        rp_q   <= fall;
        hp_q   <= hold_nx;
      end
    end

    assign pressed[k]       = p_q;
    assign press_pulse[k]   = pp_q;
    assign release_pulse[k] = rp_q;
    assign hold_pulse[k]    = hp_q;
  end

  assign any_pressed = |pressed;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/hold counts.
// Inputs change 1 time unit after each rising edge.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] key_n = 2'b11;
  logic [1:0] pressed, press_pulse, release_pulse, hold_pulse;
  logic       any_pressed;

  int tests = 0;
  int fails = 0;

  key_conditioner #(
    .N_KEYS(2),
    .DEBOUNCE_TICKS(4),
    .HOLD_TICKS(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .hold_pulse(hold_pulse),
    .any_pressed(any_pressed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    key_n = 2'b11;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    logic [6:0] o;
    rst   = 1'b1;
    key_n = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      o = {pressed, press_pulse, release_pulse, any_pressed};
      tests++;
      if (o !== 7'd0) begin
        fails++;
        $display("FAIL reset_outputs cyc %0d got %b exp 0", i, o);
      end
    end
    rst = 1'b0;
    repeat (5) tick();
    tests++;
    if (pressed !== 2'b00) begin
      fails++;
      $display("FAIL reset_early got %b exp 00", pressed);
    end
    tick();
    tests++;
    if (pressed !== 2'b11 || press_pulse !== 2'b11 || any_pressed !== 1'b1) begin
      fails++;
      $display("FAIL reset_press got p=%b pp=%b exp 11/11", pressed, press_pulse);
    end
    tick();
    tests++;
    if (press_pulse !== 2'b00 || pressed !== 2'b11) begin
      fails++;
      $display("FAIL reset_pulse_len got pp=%b p=%b exp 00/11", press_pulse, pressed);
    end
    settle();
    tests++;
    if (pressed !== 2'b00) begin
      fails++;
      $display("FAIL reset_release got %b exp 00", pressed);
    end
  endtask

  task automatic test_clean_press();
    key_n = 2'b10;
    repeat (5) tick();
    tests++;
    if (pressed[0] !== 1'b0) begin
      fails++;
      $display("FAIL clean_early got %b exp 0", pressed[0]);
    end
    tick();
    tests++;
    if (pressed !== 2'b01 || press_pulse !== 2'b01 || any_pressed !== 1'b1) begin
      fails++;
      $display("FAIL clean_press got p=%b pp=%b a=%b exp 01/01/1",
               pressed, press_pulse, any_pressed);
    end
    tick();
    tests++;
    if (press_pulse !== 2'b00) begin
      fails++;
      $display("FAIL clean_pulse_len got %b exp 00", press_pulse);
    end
    key_n = 2'b11;
    repeat (6) tick();
    tests++;
    if (release_pulse !== 2'b01 || pressed !== 2'b00 || any_pressed !== 1'b0) begin
      fails++;
      $display("FAIL clean_release got rp=%b p=%b exp 01/00", release_pulse, pressed);
    end
    settle();
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 3) key_n = 2'b10;
      else if (i < 4) key_n = 2'b11;
      else if (i < 7) key_n = 2'b10;
      else key_n = 2'b11;
      tick();
      pat = {pressed[0], press_pulse[0], release_pulse[0], hold_pulse[0]};
      if (pat !== 4'd0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bounce got %0d active cycles exp 0", bad);
    end
  endtask

  task automatic test_hold();
    int pt, ht, hc, rt;
    pt = -1; ht = -1; hc = 0; rt = -1;
    key_n = 2'b01;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (press_pulse[1] && pt < 0) pt = i;
      if (hold_pulse[1]) begin
        hc++;
        if (ht < 0) ht = i;
      end
    end
    key_n = 2'b11;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (release_pulse[1] && rt < 0) rt = i;
      if (hold_pulse[1]) hc++;
    end
    tests++;
    if (pt != 6) begin
      fails++;
      $display("FAIL hold_press_time got %0d exp 6", pt);
    end
    tests++;
    if (ht != pt + 10) begin
      fails++;
      $display("FAIL hold_time got %0d exp %0d", ht, pt + 10);
    end
    tests++;
    if (hc != 1) begin
      fails++;
      $display("FAIL hold_count got %0d exp 1", hc);
    end
    tests++;
    if (rt != 6) begin
      fails++;
      $display("FAIL hold_release_time got %0d exp 6", rt);
    end
    settle();
  endtask

  task automatic test_release_before_hold();
    int pt, rt, hc;
    pt = -1; rt = -1; hc = 0;
    key_n = 2'b10;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (i == 10) key_n = 2'b11;
      if (press_pulse[0] && pt < 0) pt = i;
      if (release_pulse[0] && rt < 0) rt = i;
      if (hold_pulse[0]) hc++;
    end
    tests++;
    if (pt != 6 || rt != 16) begin
      fails++;
      $display("FAIL rbh_times got press %0d rel %0d exp 6 16", pt, rt);
    end
    tests++;
    if (hc != 0) begin
      fails++;
      $display("FAIL rbh_no_hold got %0d exp 0", hc);
    end
    settle();
  endtask

  task automatic test_independent();
    int p0, p1, h0, h1, both;
    p0 = -1; p1 = -1; h0 = -1; h1 = -1; both = 0;
    key_n = 2'b10;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (i == 2) key_n = 2'b00;
      if (press_pulse[0] && p0 < 0) p0 = i;
      if (press_pulse[1] && p1 < 0) p1 = i;
      if (hold_pulse[0] && h0 < 0) h0 = i;
      if (hold_pulse[1] && h1 < 0) h1 = i;
      if ((press_pulse & release_pulse) != 2'b00) both++;
    end
    tests++;
    if (p0 != 6 || p1 != 8) begin
      fails++;
      $display("FAIL indep_press got %0d %0d exp 6 8", p0, p1);
    end
    tests++;
    if (h0 != 16 || h1 != 18) begin
      fails++;
      $display("FAIL indep_hold got %0d %0d exp 16 18", h0, h1);
    end
    tests++;
    if (both != 0) begin
      fails++;
      $display("FAIL indep_pulse_overlap got %0d exp 0", both);
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold();
    test_release_before_hold();
    test_independent();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
